rob_allocator: RTL and testbench

In-order slot allocator for the reorder buffer: hands out reorder-buffer/issue-queue indices to dispatching instructions and supplies the `oldest0`/`oldest1` retire pointers back to the buffer. It sits between decode/dispatch and the reorder buffer. It consumes the buffer's `retire0`/`retire1` outputs and produces the `iq_index` values that travel with each instruction down the pipes. It is the writer-side counterpart to the buffer's in-order retire logic: a circular head/tail manager with two-wide allocate and two-wide free.

---
 rtl/rob_allocator.sv | 119 +++++++++++
 tb/tb_rob_allocator.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/rob_allocator.sv
// In-order reorder-buffer slot allocator: circular head/tail manager with
// two-wide allocate toward dispatch and two-wide free from in-order retire.
`ifndef NUM_IQ_ENTRIES_LOG2
`define NUM_IQ_ENTRIES_LOG2 5
`endif

module rob_allocator #(
  parameter int ADDR_WIDTH = `NUM_IQ_ENTRIES_LOG2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  dispatch_req0,
  input  logic                  dispatch_req1,
  output logic                  grant0,
  output logic                  grant1,
  output logic [ADDR_WIDTH-1:0] alloc_index0,
  output logic [ADDR_WIDTH-1:0] alloc_index1,
  output logic                  stall,
  input  logic                  retire0,
  input  logic                  retire1,
  output logic [ADDR_WIDTH-1:0] oldest0,
  output logic [ADDR_WIDTH-1:0] oldest1,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  empty,
  output logic                  full
);

  localparam int                DEPTH   = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] ONE_C   = (ADDR_WIDTH + 1)'(1);
  localparam logic [ADDR_WIDTH:0] TWO_C   = (ADDR_WIDTH + 1)'(2);

  logic [ADDR_WIDTH-1:0] head_r;
  logic [ADDR_WIDTH-1:0] tail_r;
  logic [ADDR_WIDTH:0]   count_r;

  logic                  clear_s;
  logic [ADDR_WIDTH:0]   free_s;
  logic                  grant0_s;
  logic                  grant1_s;
  logic                  stall_s;
  logic [1:0]            na_s;
  logic [1:0]            nr_raw_s;
  logic [1:0]            nr_s;
  logic [ADDR_WIDTH-1:0] head_nxt_s;
  logic [ADDR_WIDTH-1:0] tail_nxt_s;
  logic [ADDR_WIDTH:0]   count_nxt_s;

  assign clear_s = reset | flush;
  // Free space comes only from registered count, so retire never feeds grant.
  assign free_s  = DEPTH_C - count_r;

  // Grant and stall decisions from registered occupancy and current requests.
  always_comb begin
    grant0_s = 1'b0;
    grant1_s = 1'b0;
    stall_s  = 1'b0;
    if (clear_s) begin
      grant0_s = 1'b0;
      grant1_s = 1'b0;
      stall_s  = 1'b0;
    end else begin
      grant0_s = dispatch_req0 && (free_s >= ONE_C);
      grant1_s = dispatch_req0 && dispatch_req1 && (free_s >= TWO_C);
      stall_s  = (dispatch_req0 && !grant0_s) ||
                 (dispatch_req0 && dispatch_req1 && !grant1_s);
    end
  end

  // Allocation/retire counts and next pointer state; retires clamp to occupancy.
  always_comb begin
    na_s        = {1'b0, grant0_s} + {1'b0, grant1_s};
    nr_raw_s    = {1'b0, retire0} + {1'b0, retire0 & retire1};
    nr_s        = nr_raw_s;
    head_nxt_s  = head_r;
    tail_nxt_s  = tail_r;
    count_nxt_s = count_r;
    if ((ADDR_WIDTH + 1)'(nr_raw_s) > count_r) begin
      nr_s = count_r[1:0];
    end else begin
      nr_s = nr_raw_s;
    end
    if (clear_s) begin
      head_nxt_s  = '0;
      tail_nxt_s  = '0;
      count_nxt_s = '0;
    end else begin
      head_nxt_s  = head_r + ADDR_WIDTH'(nr_s);
      tail_nxt_s  = tail_r + ADDR_WIDTH'(na_s);
      count_nxt_s = count_r + (ADDR_WIDTH + 1)'(na_s) - (ADDR_WIDTH + 1)'(nr_s);
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      head_r  <= '0;
      tail_r  <= '0;
      count_r <= '0;
    end else begin
      head_r  <= head_nxt_s;
      tail_r  <= tail_nxt_s;
      count_r <= count_nxt_s;
    end
  end

  assign grant0       = grant0_s;
  assign grant1       = grant1_s;
  assign stall        = stall_s;
  assign alloc_index0 = tail_r;
  assign alloc_index1 = tail_r + ADDR_WIDTH'(1);
  assign oldest0      = head_r;
  assign oldest1      = head_r + ADDR_WIDTH'(1);
  assign count        = count_r;
  assign empty        = (count_r == '0);
  assign full         = (count_r == DEPTH_C);

endmodule

// File: tb/tb_rob_allocator.sv
// Scoreboard bench for rob_allocator: a reference model pushes expected
// outputs per driven cycle, which are popped and compared mid-cycle.
`timescale 1ns/1ps

module tb_rob_allocator;

  localparam int AW    = 5;
  localparam int DEPTH = 32;

  logic          clk = 1'b0;
  logic          reset, flush, dispatch_req0, dispatch_req1, retire0, retire1;
  logic          grant0, grant1, stall, empty, full;
  logic [AW-1:0] alloc_index0, alloc_index1, oldest0, oldest1;
  logic [AW:0]   count;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic          g0, g1, st, emp, ful;
    logic [AW-1:0] i0, i1, o0, o1;
    logic [AW:0]   cnt;
  } exp_t;

  exp_t exp_q[$];

  int m_head, m_tail, m_count;

  always #5 clk = ~clk;

  rob_allocator #(.ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .dispatch_req0(dispatch_req0), .dispatch_req1(dispatch_req1),
    .grant0(grant0), .grant1(grant1),
    .alloc_index0(alloc_index0), .alloc_index1(alloc_index1),
    .stall(stall), .retire0(retire0), .retire1(retire1),
    .oldest0(oldest0), .oldest1(oldest1),
    .count(count), .empty(empty), .full(full)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, want);
    end
  endtask

  // One clock cycle: drive, predict, compare at negedge, advance model at posedge.
  task automatic step(input logic r0, input logic r1, input logic t0, input logic t1,
                      input logic fl, input logic rs);
    exp_t e, g;
    int   free, na, nr;
    logic clr;
    reset = rs; flush = fl;
    dispatch_req0 = r0; dispatch_req1 = r1; retire0 = t0; retire1 = t1;
    clr  = rs | fl;
    free = DEPTH - m_count;
    e.g0 = !clr && r0 && (free >= 1);
    e.g1 = !clr && r0 && r1 && (free >= 2);
    e.st = !clr && ((r0 && !e.g0) || (r0 && r1 && !e.g1));
    e.i0 = AW'(m_tail);
    e.i1 = AW'((m_tail + 1) % DEPTH);
    e.o0 = AW'(m_head);
    e.o1 = AW'((m_head + 1) % DEPTH);
    e.cnt = (AW + 1)'(m_count);
    e.emp = (m_count == 0);
    e.ful = (m_count == DEPTH);
    exp_q.push_back(e);
    na = int'(e.g0) + int'(e.g1);
    nr = int'(t0) + int'(t0 && t1);
    if (nr > m_count) nr = m_count;
    @(negedge clk);
    g = exp_q.pop_front();
    check_eq("grant0", 32'(grant0), 32'(g.g0));
    check_eq("grant1", 32'(grant1), 32'(g.g1));
    check_eq("stall", 32'(stall), 32'(g.st));
    check_eq("alloc_index0", 32'(alloc_index0), 32'(g.i0));
    check_eq("alloc_index1", 32'(alloc_index1), 32'(g.i1));
    check_eq("oldest0", 32'(oldest0), 32'(g.o0));
    check_eq("oldest1", 32'(oldest1), 32'(g.o1));
    check_eq("count", 32'(count), 32'(g.cnt));
    check_eq("empty", 32'(empty), 32'(g.emp));
    check_eq("full", 32'(full), 32'(g.ful));
    if (clr) begin
      m_head = 0; m_tail = 0; m_count = 0;
    end else begin
      m_head  = (m_head + nr) % DEPTH;
      m_tail  = (m_tail + na) % DEPTH;
      m_count = m_count + na - nr;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    reset = 1'b0; flush = 1'b0;
    dispatch_req0 = 1'b0; dispatch_req1 = 1'b0; retire0 = 1'b0; retire1 = 1'b0;
    #1;
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0;
    dispatch_req0 = 1'b0; dispatch_req1 = 1'b0; retire0 = 1'b0; retire1 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    m_head = 0; m_tail = 0; m_count = 0;
    idle_inputs();
    check_eq("rst_oldest1", 32'(oldest1), 32'd1);
    check_eq("rst_alloc_index1", 32'(alloc_index1), 32'd1);
    check_eq("rst_empty", 32'(empty), 32'd1);

    // Fill with 16 two-wide dispatches.
    for (int i = 0; i < 16; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("fill_count", 32'(count), 32'd32);
    check_eq("fill_full", 32'(full), 32'd1);
    dispatch_req0 = 1'b1; dispatch_req1 = 1'b1; #1;
    check_eq("full_stall", 32'(stall), 32'd1);
    check_eq("full_grant0", 32'(grant0), 32'd0);
    // Retire this cycle does not free a slot until the next.
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    check_eq("after_ret_count", 32'(count), 32'd31);
    check_eq("after_ret_oldest0", 32'(oldest0), 32'd1);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("wrap_tail", 32'(alloc_index0), 32'd1);

    // Drain, then build count=10 head=28 tail=6.
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 14; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 14; i++) step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("ss_pre_count", 32'(count), 32'd10);
    check_eq("ss_pre_head", 32'(oldest0), 32'd28);
    check_eq("ss_pre_tail", 32'(alloc_index0), 32'd6);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    check_eq("ss_count", 32'(count), 32'd10);
    check_eq("ss_head", 32'(oldest0), 32'd12);
    check_eq("ss_tail", 32'(alloc_index0), 32'd22);

    // Ignored lone req1 and lone retire1.
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    check_eq("ignored_count", 32'(count), 32'd10);
    check_eq("ignored_head", 32'(oldest0), 32'd12);

    // Flush and then reset at count=20 with pending traffic.
    for (int k = 0; k < 2; k++) begin
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      check_eq("pre_clear_count", 32'(count), 32'd20);
      step(1'b1, 1'b1, 1'b1, 1'b1, (k == 0), (k == 1));
      idle_inputs();
      check_eq("clear_count", 32'(count), 32'd0);
      check_eq("clear_oldest0", 32'(oldest0), 32'd0);
      check_eq("clear_alloc0", 32'(alloc_index0), 32'd0);
      check_eq("clear_empty", 32'(empty), 32'd1);
      step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    end

    // Over-retire guard.
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    check_eq("over_ret_count", 32'(count), 32'd0);
    check_eq("over_ret_head", 32'(oldest0), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
